// File: rtl/amo_rmw_sequencer.sv
// RV32A atomic read-modify-write sequencer for the MA stage: one AMO/LR/SC at a time,
// fixed five-cycle read -> capture -> write -> result flow with an LR/SC reservation.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic            write_enable;
        logic [XLEN-1:0] write_address;
        logic [XLEN-1:0] write_data;
    } amo_interface_t;
endpackage

module amo_rmw_sequencer #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MMIO_ADDR = 32'h4000_0000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_amo_valid,
    input  logic [4:0]                i_amo_funct5,
    input  logic [XLEN-1:0]           i_rs1_data,
    input  logic [XLEN-1:0]           i_rs2_data,
    input  logic [XLEN-1:0]           i_mem_read_data,
    input  logic                      i_snoop_store_valid,
    input  logic [XLEN-1:0]           i_snoop_store_address,
    output logic                      o_mem_read_enable,
    output logic [XLEN-1:0]           o_mem_read_address,
    output riscv_pkg::amo_interface_t o_amo,
    output logic                      o_stall,
    output logic [XLEN-1:0]           o_result,
    output logic                      o_result_valid,
    output logic [2:0]                o_dbg_state
);

    // Handshake: i_amo_valid is held by the pipeline while o_stall is high; the
    // request is taken only from IDLE, and o_result_valid is a single-cycle strobe.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    state_t          state_q, state_d;
    logic [4:0]      funct5_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] old_q;
    logic            sc_fail_q;
    logic            resv_valid_q;
    logic [XLEN-1:0] resv_addr_q;

    logic            stall;
    logic            rd_en;
    logic            res_valid;
    logic            do_write;
    logic [XLEN-1:0] wdata;
    logic            wr_fire;
    logic            resv_match;
    logic            lr_set;
    logic            resv_clear;
    logic [XLEN-1:0] snoop_word;

    // Low address bits are irrelevant once requests are aligned to words.
    logic unused_bits;
    assign unused_bits = ^{i_rs1_data[1:0], i_snoop_store_address[1:0], MMIO_ADDR};

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        rd_en     = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = i_amo_valid & ~i_flush;
                if (i_amo_valid && !i_flush) state_d = S_READ;
            end
            S_READ: begin
                stall   = 1'b1;
                rd_en   = 1'b1;
                state_d = i_flush ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                stall   = 1'b1;
                state_d = i_flush ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                stall   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resv_match = resv_valid_q && (resv_addr_q == addr_q);

    always_comb begin
        wdata    = old_q;
        do_write = 1'b1;
        case (funct5_q)
            F_ADD:  wdata = old_q + rs2_q;
            F_SWAP: wdata = rs2_q;
            F_XOR:  wdata = old_q ^ rs2_q;
            F_OR:   wdata = old_q | rs2_q;
            F_AND:  wdata = old_q & rs2_q;
            F_MIN:  wdata = ($signed(old_q) < $signed(rs2_q)) ? old_q : rs2_q;
            F_MAX:  wdata = ($signed(old_q) > $signed(rs2_q)) ? old_q : rs2_q;
            F_MINU: wdata = (old_q < rs2_q) ? old_q : rs2_q;
            F_MAXU: wdata = (old_q > rs2_q) ? old_q : rs2_q;
            F_LR:   do_write = 1'b0;
            F_SC: begin
                wdata    = rs2_q;
                do_write = resv_match;
            end
            default: do_write = 1'b0;
        endcase
    end

    // Reset is combinationally masked so a reset landing in WRITE never commits.
    assign wr_fire    = (state_q == S_WRITE) && do_write && !i_rst;
    assign lr_set     = (state_q == S_WRITE) && (funct5_q == F_LR);
    assign snoop_word = {i_snoop_store_address[XLEN-1:2], 2'b00};
    assign resv_clear = ((state_q == S_WRITE) && (funct5_q == F_SC))
                      || (i_snoop_store_valid && (snoop_word == resv_addr_q))
                      || (wr_fire && (addr_q == resv_addr_q));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            funct5_q     <= '0;
            addr_q       <= '0;
            rs2_q        <= '0;
            old_q        <= '0;
            sc_fail_q    <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_amo_valid && !i_flush) begin
                funct5_q <= i_amo_funct5;
                rs2_q    <= i_rs2_data;
                addr_q   <= {i_rs1_data[XLEN-1:2], 2'b00};
            end
            if (state_q == S_CAPTURE) old_q <= i_mem_read_data;
            if (state_q == S_WRITE) sc_fail_q <= ~resv_match;
            // An LR completing in the same cycle as a matching snoop keeps its reservation.
            if (lr_set) begin
                resv_valid_q <= 1'b1;
                resv_addr_q  <= addr_q;
            end else if (resv_clear) begin
                resv_valid_q <= 1'b0;
            end
        end
    end

    assign o_stall            = stall & ~i_rst;
    assign o_mem_read_enable  = rd_en & ~i_rst;
    assign o_mem_read_address = o_mem_read_enable ? addr_q : '0;
    assign o_amo.write_enable  = wr_fire;
    assign o_amo.write_address = wr_fire ? addr_q : '0;
    assign o_amo.write_data    = wr_fire ? wdata : '0;
    assign o_result_valid     = res_valid & ~i_rst;
    assign o_result           = !o_result_valid ? '0 :
                                (funct5_q == F_SC) ? {{(XLEN-1){1'b0}}, sc_fail_q} : old_q;
    assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_amo_rmw_sequencer.sv
// Bench for amo_rmw_sequencer: directed latency/LR-SC/flush/reset cases then random AMOs,
// scored against a word-memory + reservation reference model.
module tb_amo_rmw_sequencer;
    localparam int XLEN = 32;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    localparam int M_NORMAL    = 0;
    localparam int M_FLUSH     = 1;
    localparam int M_RESET     = 2;
    localparam int M_SNOOP_WR  = 3;

    // ---------------- clock / reset / DUT ----------------
    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_flush;
    logic            i_amo_valid;
    logic [4:0]      i_amo_funct5;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [XLEN-1:0] i_mem_read_data;
    logic            i_snoop_store_valid;
    logic [XLEN-1:0] i_snoop_store_address;
    logic            o_mem_read_enable;
    logic [XLEN-1:0] o_mem_read_address;
    riscv_pkg::amo_interface_t o_amo;
    logic            o_stall;
    logic [XLEN-1:0] o_result;
    logic            o_result_valid;
    logic [2:0]      o_dbg_state;

    always #5 i_clk = ~i_clk;

    amo_rmw_sequencer #(.XLEN(XLEN), .MMIO_ADDR(32'h4000_0000)) dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_flush               (i_flush),
        .i_amo_valid           (i_amo_valid),
        .i_amo_funct5          (i_amo_funct5),
        .i_rs1_data            (i_rs1_data),
        .i_rs2_data            (i_rs2_data),
        .i_mem_read_data       (i_mem_read_data),
        .i_snoop_store_valid   (i_snoop_store_valid),
        .i_snoop_store_address (i_snoop_store_address),
        .o_mem_read_enable     (o_mem_read_enable),
        .o_mem_read_address    (o_mem_read_address),
        .o_amo                 (o_amo),
        .o_stall               (o_stall),
        .o_result              (o_result),
        .o_result_valid        (o_result_valid),
        .o_dbg_state           (o_dbg_state)
    );

    // ---------------- memories and reference model state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] dut_mem [logic [XLEN-1:0]];
    logic [XLEN-1:0] ref_mem [logic [XLEN-1:0]];
    logic            ref_resv_valid;
    logic [XLEN-1:0] ref_resv_addr;

    logic [XLEN-1:0]   exp_q[$];
    logic [2*XLEN-1:0] exp_wr_q[$];

    // Memory side of the DUT: data returns the cycle after a read request.
    always @(posedge i_clk) begin
        if (o_mem_read_enable)
            i_mem_read_data <= dut_mem.exists(o_mem_read_address) ? dut_mem[o_mem_read_address] : '0;
        if (o_amo.write_enable)
            dut_mem[o_amo.write_address] = o_amo.write_data;
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] val);
        dut_mem[addr] = val;
        ref_mem[addr] = val;
    endtask

    // Reference semantics of one AMO applied to the model memory and reservation.
    task automatic model_op(input logic [4:0] f5, input logic [XLEN-1:0] word,
                            input logic [XLEN-1:0] rs2, output logic wr,
                            output logic [XLEN-1:0] wdata, output logic [XLEN-1:0] res);
        logic [XLEN-1:0] old;
        int so, sr;
        old   = ref_mem.exists(word) ? ref_mem[word] : '0;
        so    = int'(old);
        sr    = int'(rs2);
        wr    = 1'b1;
        wdata = '0;
        res   = old;
        case (f5)
            F_ADD:  wdata = old + rs2;
            F_SWAP: wdata = rs2;
            F_XOR:  wdata = old ^ rs2;
            F_OR:   wdata = old | rs2;
            F_AND:  wdata = old & rs2;
            F_MIN:  wdata = (so < sr) ? old : rs2;
            F_MAX:  wdata = (so < sr) ? rs2 : old;
            F_MINU: wdata = (old < rs2) ? old : rs2;
            F_MAXU: wdata = (old < rs2) ? rs2 : old;
            F_LR: begin
                wr = 1'b0;
                ref_resv_valid = 1'b1;
                ref_resv_addr  = word;
            end
            F_SC: begin
                if (ref_resv_valid && ref_resv_addr == word) begin
                    wdata = rs2;
                    res   = 0;
                end else begin
                    wr  = 1'b0;
                    res = 1;
                end
                ref_resv_valid = 1'b0;
            end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            ref_mem[word] = wdata;
            if (ref_resv_valid && ref_resv_addr == word) ref_resv_valid = 1'b0;
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_stall"},   o_stall, 0);
        chk({name, "_rd_en"},   o_mem_read_enable, 0);
        chk({name, "_rd_addr"}, o_mem_read_address, 0);
        chk({name, "_we"},      o_amo.write_enable, 0);
        chk({name, "_wdata"},   o_amo.write_data, 0);
        chk({name, "_rvalid"},  o_result_valid, 0);
        chk({name, "_result"},  o_result, 0);
        chk({name, "_state"},   o_dbg_state, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic snoop(input logic [XLEN-1:0] addr);
        @(negedge i_clk);
        i_snoop_store_valid   = 1'b1;
        i_snoop_store_address = addr;
        if (ref_resv_valid && ref_resv_addr == {addr[XLEN-1:2], 2'b00}) ref_resv_valid = 1'b0;
        @(negedge i_clk);
        i_snoop_store_valid = 1'b0;
    endtask

    task automatic do_op(input logic [4:0] f5, input logic [XLEN-1:0] rs1,
                         input logic [XLEN-1:0] rs2, input int mode);
        logic [XLEN-1:0] word, wdata, res;
        logic            wr;
        word = {rs1[XLEN-1:2], 2'b00};
        wr   = 1'b0;

        @(negedge i_clk);  // cycle 0: detect
        i_amo_valid  = 1'b1;
        i_amo_funct5 = f5;
        i_rs1_data   = rs1;
        i_rs2_data   = rs2;
        if (mode == M_NORMAL || mode == M_SNOOP_WR) begin
            model_op(f5, word, rs2, wr, wdata, res);
            if (wr) exp_wr_q.push_back({word, wdata});
            exp_q.push_back(res);
        end
        #1;
        chk("c0_stall", o_stall, 1);
        chk("c0_rd_en", o_mem_read_enable, 0);

        @(negedge i_clk);  // cycle 1: read
        #1;
        chk("c1_rd_en", o_mem_read_enable, 1);
        chk("c1_rd_addr", o_mem_read_address, word);
        chk("c1_stall", o_stall, 1);

        @(negedge i_clk);  // cycle 2: capture
        if (mode == M_FLUSH) i_flush = 1'b1;
        #1;
        chk("c2_stall", o_stall, 1);
        chk("c2_rd_en", o_mem_read_enable, 0);

        @(negedge i_clk);  // cycle 3: write
        if (mode == M_FLUSH) begin
            i_flush     = 1'b0;
            i_amo_valid = 1'b0;
            #1;
            chk_quiet("flush_c3");
            repeat (2) @(negedge i_clk);
            return;
        end
        if (mode == M_RESET) begin
            i_rst = 1'b1;
            ref_resv_valid = 1'b0;
            #1;
            chk("rst_c3_we", o_amo.write_enable, 0);
            chk("rst_c3_stall", o_stall, 0);
            @(negedge i_clk);
            i_rst       = 1'b0;
            i_amo_valid = 1'b0;
            #1;
            chk_quiet("rst_c4");
            return;
        end
        if (mode == M_SNOOP_WR) begin
            i_snoop_store_valid   = 1'b1;
            i_snoop_store_address = word | 32'h2;
        end
        #1;
        chk("c3_we", o_amo.write_enable, wr);
        chk("c3_stall", o_stall, 1);

        @(negedge i_clk);  // cycle 4: result, stall released
        i_snoop_store_valid = 1'b0;
        i_amo_valid         = 1'b0;
        #1;
        chk("c4_rvalid", o_result_valid, 1);
        chk("c4_stall", o_stall, 0);
        chk("c4_we", o_amo.write_enable, 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [2*XLEN-1:0] ew;
        forever begin
            @(negedge i_clk);
            #2;
            if (o_amo.write_enable) begin
                chk("write_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) begin
                    ew = exp_wr_q.pop_front();
                    chk("write_addr", o_amo.write_address, ew[2*XLEN-1:XLEN]);
                    chk("write_data", o_amo.write_data, ew[XLEN-1:0]);
                end
            end
            if (o_result_valid) begin
                chk("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("result", o_result, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [4:0] f5_tab [13];

    initial begin
        logic [XLEN-1:0] rs2;
        int              k;
        f5_tab = '{F_ADD, F_SWAP, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU,
                   F_LR, F_SC, 5'b00101, 5'b11111};

        i_rst = 1'b1; i_flush = 1'b0; i_amo_valid = 1'b0; i_amo_funct5 = '0;
        i_rs1_data = '0; i_rs2_data = '0; i_mem_read_data = '0;
        i_snoop_store_valid = 1'b0; i_snoop_store_address = '0;
        ref_resv_valid = 1'b0; ref_resv_addr = '0;
        for (int a = 0; a < 32; a++) preload(32'h100 + 4 * a, $urandom());

        repeat (3) @(negedge i_clk);
        i_amo_valid = 1'b1;
        #1;
        chk_quiet("reset");
        i_rst = 1'b0;
        i_amo_valid = 1'b0;

        // Latency and basic arithmetic
        preload(32'h100, 5);
        do_op(F_ADD, 32'h100, 7, M_NORMAL);
        preload(32'h104, 32'hFFFF_FFFF);
        do_op(F_MIN, 32'h104, 1, M_NORMAL);
        preload(32'h104, 32'hFFFF_FFFF);
        do_op(F_MINU, 32'h104, 1, M_NORMAL);

        // LR/SC pairing and reservation loss
        do_op(F_LR, 32'h100, 0, M_NORMAL);
        do_op(F_SC, 32'h100, 9, M_NORMAL);
        do_op(F_SC, 32'h100, 9, M_NORMAL);
        do_op(F_LR, 32'h100, 0, M_NORMAL);
        snoop(32'h102);
        do_op(F_SC, 32'h100, 3, M_NORMAL);
        do_op(F_LR, 32'h108, 0, M_SNOOP_WR);
        do_op(F_SC, 32'h108, 4, M_NORMAL);
        do_op(F_LR, 32'h10C, 0, M_NORMAL);
        do_op(F_ADD, 32'h10C, 1, M_NORMAL);
        do_op(F_SC, 32'h10C, 2, M_NORMAL);

        // Flush, unaligned address, reset in WRITE
        do_op(F_ADD, 32'h110, 3, M_FLUSH);
        do_op(F_ADD, 32'h110, 3, M_NORMAL);
        do_op(F_SWAP, 32'h103, 32'hA5A5_0001, M_NORMAL);
        do_op(F_LR, 32'h114, 0, M_NORMAL);
        do_op(F_SWAP, 32'h118, 32'hDEAD_BEEF, M_RESET);
        do_op(F_SC, 32'h114, 6, M_NORMAL);
        do_op(F_LR, 32'h11C, 0, M_NORMAL);
        do_op(F_XOR, 32'h11C, 32'h0F0F_0F0F, M_FLUSH);
        do_op(F_SC, 32'h11C, 8, M_NORMAL);

        // Randomized traffic over a small window so addresses collide often
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 15);
            if (k > 12) k = $urandom_range(9, 10);
            case ($urandom_range(0, 3))
                0:       rs2 = 32'h8000_0000;
                1:       rs2 = 32'h7FFF_FFFF;
                default: rs2 = $urandom();
            endcase
            if ($urandom_range(0, 9) == 0)
                snoop(32'h100 + $urandom_range(0, 31));
            do_op(f5_tab[k], 32'h100 + $urandom_range(0, 31), rs2,
                  ($urandom_range(0, 19) == 0) ? M_FLUSH : M_NORMAL);
        end

        repeat (3) @(negedge i_clk);
        chk("pending_results", exp_q.size(), 0);
        chk("pending_writes", exp_wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amo_rmw_sequencer.md
AMO_RMW_SEQUENCER -- requirements
Module: amo_rmw_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter MMIO_ADDR, default 32'h4000_0000, MMIO base (passed through only; no cache gating here).
REQ-003 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_flush  in  1  pipeline flush/trap.
REQ-006 SHALL have port i_amo_valid  in  1  AMO/LR/SC in MA stage, held while o_stall is high.
REQ-007 SHALL have port i_amo_funct5  in  5  RV32A funct5.
REQ-008 SHALL have port i_rs1_data  in  XLEN  address.
REQ-009 SHALL have port i_rs2_data  in  XLEN  operand.
REQ-010 SHALL have port i_mem_read_data  in  XLEN  read data, valid the cycle after o_mem_read_enable.
REQ-011 SHALL have port i_snoop_store_valid  in  1  committed non-AMO store.
REQ-012 SHALL have port i_snoop_store_address  in  XLEN  address of that store.
REQ-013 SHALL have port o_mem_read_enable / o_mem_read_address  out  1 / XLEN  RMW read request.
REQ-014 SHALL have port o_amo  out  riscv_pkg::amo_interface_t  write_enable, write_address, write_data to memory and cache write path.
REQ-015 SHALL have port o_stall  out  1  hold pipeline.
REQ-016 SHALL have port o_result / o_result_valid  out  XLEN / 1  rd value and its strobe.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> CAPTURE -> WRITE -> DONE -> IDLE.
REQ-018 SHALL drive o_stall = i_amo_valid & ~i_flush in IDLE, 1 in READ/CAPTURE/WRITE, and 0 in DONE.
REQ-019 SHALL leave IDLE for READ when i_amo_valid & ~i_flush, latching funct5, rs2, and the word address {rs1[XLEN-1:2],2'b00}.
REQ-020 SHALL assert o_mem_read_enable only in READ, with o_mem_read_address = latched word address.
REQ-021 SHALL register i_mem_read_data into old_value in CAPTURE.
REQ-022 SHALL assert o_amo.write_enable only in WRITE, for exactly one cycle, with write_address = latched word address.
REQ-023 SHALL compute write_data as: ADD 00000 old+rs2 (mod 2^XLEN); SWAP 00001 rs2; XOR 00100; OR 01000; AND 01100; MIN 10000 and MAX 10100 signed; MINU 11000 and MAXU 11100 unsigned.
REQ-024 SHALL, for LR (00010), suppress the write and set reservation valid with reservation address = word address.
REQ-025 SHALL, for SC (00011), write rs2 and return 0 iff the reservation is valid and the addresses match; otherwise it SHALL suppress the write and return 1.
REQ-026 SHALL clear the reservation on every SC regardless of outcome.
REQ-027 SHALL clear the reservation on i_snoop_store_valid to the reserved word, and on any completed AMO write to the reserved word.
REQ-028 SHALL, for unsupported funct5, suppress the write and return old_value.
REQ-029 SHALL set o_result = old_value (or the SC status) with o_result_valid = 1 in DONE, for one cycle.
REQ-030 SHALL give fixed latency: detect cycle 0, read cycle 1, capture cycle 2, write cycle 3, result/stall release cycle 4.
REQ-031 SHALL, on i_flush in READ or CAPTURE, abort to IDLE with no write and no result.
REQ-032 SHALL ignore i_flush in WRITE and DONE, because the write is already committed.
REQ-033 SHALL NOT restart on i_amo_valid in DONE; a new AMO is accepted only from IDLE.
REQ-034 SHALL give a same-cycle snoop and LR set priority to the LR set.

Reset
REQ-035 SHALL, on i_rst, set state to IDLE, clear the reservation, and drive every output to 0; i_rst mid-operation SHALL abort with no write.

Verification
REQ-036 SHALL pass: AMOADD, mem=5, rs2=7 -> read cycle 1, write 12 in cycle 3, o_result=5 in cycle 4, stall cycles 0-3.
REQ-037 SHALL pass: AMOMIN, mem=32'hFFFF_FFFF, rs2=1 -> write 32'hFFFF_FFFF; AMOMINU with same values -> write 1.
REQ-038 SHALL pass: LR 0x100, then SC 0x100 rs2=9 -> write 9, result 0; a second SC -> no write, result 1.
REQ-039 SHALL pass: LR 0x100, then snoop store 0x102, then SC 0x100 -> no write, result 1.
REQ-040 SHALL pass: flush in CAPTURE -> no o_amo.write_enable, no o_result_valid, IDLE next cycle.
REQ-041 SHALL pass: rs1 = 0x103 -> read/write address 0x100; i_rst in WRITE -> outputs 0 the next cycle.
